ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Registered, parametrised successor to the combinational immediate extender.
- Extends immediates in zero, sign, high (lui) and branch-offset modes, and extends load data in lb/lbu/lh/lhu modes with byte-lane selection.
- Sits between the decode/memory stage and its consumer behind a valid/ready handshake, with a 2-entry output buffer and synchronous flush.
- Detects misaligned halfword selects and counts them.

Parameters:
- IN_W, 16: immediate width. Must satisfy 2 <= IN_W < OUT_W.
- OUT_W, 32: result and load-data width. Must be a multiple of 16.
- TAG_W, 5: width of the sideband tag (destination register number), carried unchanged.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous; discards all buffered and incoming entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  block can accept an entry.
- in_op  in  3  mode: 0 zero, 1 sign, 2 high, 3 branch, 4 lb, 5 lbu, 6 lh, 7 lhu.
- in_data  in  OUT_W  modes 0-3 use bits [IN_W-1:0]; modes 4-7 use the full load word.
- in_off  in  clog2(OUT_W/8)  byte offset for modes 4-7; ignored for modes 0-3.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_result  out  OUT_W  extended value.
- out_tag  out  TAG_W  tag of the head entry.
- out_err  out  1  head entry had a misaligned halfword select.
- err_cnt  out  ERRCNT_W  saturating count of accepted erroneous entries.

Behaviour:
- Reset (reset=0, asynchronous): buffer empty, out_valid=0, out_result=0, out_tag=0, out_err=0, err_cnt=0; in_ready=0 while reset is asserted. Reset asserted mid-transfer discards all buffered entries.
- Accept: in_valid & in_ready at a rising edge. Push: result computed combinationally from the inputs is written into the buffer. Latency 1 cycle: an entry accepted into an empty buffer has out_valid=1 on the next cycle.
- Pop: out_valid & out_ready at a rising edge removes the head entry.
- Buffer: 2 entries, FIFO order, count 0..2. in_ready = reset deasserted & count<2 & !flush. in_ready depends on registered state only, never on out_ready.
- Simultaneous push and pop at count 1: count stays 1; the new entry becomes head on the next cycle. Simultaneous push and pop at count 0 is impossible, since out_valid=0.
- Full (count=2): in_ready=0; a pop frees one slot for the following cycle.
- Flush: at the edge, count becomes 0 and out_valid becomes 0. Any in_valid in the flush cycle is dropped (in_ready=0). err_cnt is not cleared by flush.
- Output payload (out_result, out_tag, out_err) comes from the head slot and is held stable while out_valid & !out_ready.
- Mode 0 (zero): zero-extend the IN_W-bit immediate to OUT_W.
- Mode 1 (sign): sign-extend the immediate, replicating bit IN_W-1.
- Mode 2 (high): immediate in bits [OUT_W-1:OUT_W-IN_W], zeros below.
- Mode 3 (branch): sign-extend the immediate, then shift left 2. Bits shifted beyond OUT_W are discarded.
- Mode 4/5 (lb/lbu): select byte in_off, i.e. in_data[8*in_off+7 : 8*in_off]; sign-extend (lb) or zero-extend (lbu).
- Mode 6/7 (lh/lhu): select halfword at byte offset in_off, i.e. in_data[8*in_off+15 : 8*in_off].
  - in_off must be even; sign-extend (lh) or zero-extend (lhu).
  - If in_off[0]=1: out_result=0 and out_err=1 for that entry.
- err_cnt: increments by 1 on each accepted entry with the error condition, saturating at all-ones. It is not incremented for entries dropped by flush.

Decomposition:
- Shared constants package: the mode encodings ext_zero=0, ext_sign=1, ext_high=2, ext_branch=3, ext_lb=4, ext_lbu=5, ext_lh=6, ext_lhu=7, and the 3-bit mode width. The existing 2-bit ext_zero/ext_sign/ext_high macros keep values 0..2 so existing decoders remain compatible.
- Sub-module ext_core: purely combinational extension, mode × data × offset → result, err.
- The top module holds the 2-entry buffer, handshake, flush and error counter.

Test Plan:
- Defaults, mode 1, in_data=16'h8001, out_ready=1 → result 32'hFFFF8001 one cycle later. Mode 2 with 16'h1234 → 32'h12340000. Mode 3 with 16'hFFFF → 32'hFFFFFFFC.
- Mode 4, in_data=32'h80FF7F01, in_off=3 → 32'hFFFFFF80. Mode 5 with the same inputs → 32'h00000080. Mode 6, in_off=2 → 32'hFFFF80FF.
- Mode 7, in_off=1 → out_err=1, out_result=0, err_cnt=1. Repeat 300 times → err_cnt saturates at 8'hFF.
- Hold out_ready=0, push tags 1, 2, 3 → in_ready falls after 2 accepts, tag 3 is held at the source. Release out_ready → tags emerge 1, 2, 3 in order, with payload stable while stalled.
- Buffer holds 2 entries, assert flush with in_valid=1 → next cycle out_valid=0, count 0, flushed input never appears, err_cnt unchanged.
- Pull reset low asynchronously mid-stream with 2 entries buffered → out_valid, out_result and err_cnt go to 0 immediately, without waiting for a clock edge. in_ready=0 until reset returns high.

Source files
------------

// File: rtl/ext_pipe_pkg.sv
// Shared mode encodings for the immediate / load-data extender.
`timescale 1ns/1ps
package ext_pipe_pkg;

  // Width of the extension mode field.
  localparam int EXT_MODE_W = 3;

  // Extension modes. Values 0..2 match the older 2-bit encoding, so existing
  // decoders that only produce zero/sign/high remain compatible.
  typedef enum logic [EXT_MODE_W-1:0] {
    ext_zero   = 3'd0,
    ext_sign   = 3'd1,
    ext_high   = 3'd2,
    ext_branch = 3'd3,
    ext_lb     = 3'd4,
    ext_lbu    = 3'd5,
    ext_lh     = 3'd6,
    ext_lhu    = 3'd7
  } ext_op_e;

  // Legacy 2-bit encodings used by older decoders.
  localparam logic [1:0] EXT2_ZERO = 2'd0;
  localparam logic [1:0] EXT2_SIGN = 2'd1;
  localparam logic [1:0] EXT2_HIGH = 2'd2;

endpackage

// File: rtl/ext_pipe_core.sv
// Purely combinational extender: mode x data x offset -> result, err.
`timescale 1ns/1ps
module ext_core
  import ext_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  localparam int OFF_W = $clog2(OUT_W/8)
) (
  input  logic [EXT_MODE_W-1:0] op,
  input  logic [OUT_W-1:0]      data,
  input  logic [OFF_W-1:0]      off,
  output logic [OUT_W-1:0]      result,
  output logic                  err
);

  logic [IN_W-1:0]  imm;
  logic [OUT_W-1:0] imm_sext;
  logic [OUT_W-1:0] lane;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  ext_op_e          mode;

  assign mode     = ext_op_e'(op);
  assign imm      = data[IN_W-1:0];
  assign imm_sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
  // Shift the load word so the addressed byte lane lands at bit 0.
  assign lane     = data >> {off, 3'b000};
  assign byte_v   = lane[7:0];
  assign half_v   = lane[15:0];

  // Select the extended value for the requested mode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    result = '0;
    err    = 1'b0;
    unique case (mode)
      ext_zero:   result = {{(OUT_W-IN_W){1'b0}}, imm};
      ext_sign:   result = imm_sext;
      ext_high:   result = {imm, {(OUT_W-IN_W){1'b0}}};
      ext_branch: result = imm_sext << 2;
      ext_lb:     result = {{(OUT_W-8){byte_v[7]}}, byte_v};
      ext_lbu:    result = {{(OUT_W-8){1'b0}}, byte_v};
      ext_lh, ext_lhu: begin
        if (off[0]) begin
          // Odd byte offset cannot address a halfword: flag it, return zero.
          err = 1'b1;
        end else if (mode == ext_lh) begin
          result = {{(OUT_W-16){half_v[15]}}, half_v};
        end else begin
          result = {{(OUT_W-16){1'b0}}, half_v};
        end
      end
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered extender: ext_core behind a valid/ready handshake with a 2-entry
// output FIFO, synchronous flush and a saturating misalignment counter.
`timescale 1ns/1ps
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int TAG_W    = 5,
  parameter int ERRCNT_W = 8,
  localparam int OFF_W   = $clog2(OUT_W/8)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXT_MODE_W-1:0] in_op,
  input  logic [OUT_W-1:0]      in_data,
  input  logic [OFF_W-1:0]      in_off,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_result,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err,
  output logic [ERRCNT_W-1:0]   err_cnt
);

  logic [OUT_W-1:0]    core_result;
  logic                core_err;

  // Slot 0 is always the head; slot 1 only holds data when count is 2.
  logic [OUT_W-1:0]    res_q [2];
  logic [OUT_W-1:0]    res_d [2];
  logic [TAG_W-1:0]    tag_q [2];
  logic [TAG_W-1:0]    tag_d [2];
  logic                err_q [2];
  logic                err_d [2];
  logic [1:0]          count_q, count_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                push;
  logic                pop;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .op     (in_op),
    .data   (in_data),
    .off    (in_off),
    .result (core_result),
    .err    (core_err)
  );

  // Ready comes from registered occupancy and flush only, never from out_ready.
  assign in_ready   = reset && (count_q != 2'd2) && !flush;
  assign out_valid  = (count_q != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  assign out_result = res_q[0];
  assign out_tag    = tag_q[0];
  assign out_err    = err_q[0];
  assign err_cnt    = err_cnt_q;

  // Next-state for the FIFO slots, occupancy and error counter.
  always_comb begin
    res_d     = res_q;
    tag_d     = tag_q;
    err_d     = err_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;

    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            res_d[0] = core_result;
            tag_d[0] = in_tag;
            err_d[0] = core_err;
            count_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Head leaves as the new entry arrives: new entry becomes head.
            res_d[0] = core_result;
            tag_d[0] = in_tag;
            err_d[0] = core_err;
          end else if (push) begin
            res_d[1] = core_result;
            tag_d[1] = in_tag;
            err_d[1] = core_err;
            count_d  = 2'd2;
          end else if (pop) begin
            count_d  = 2'd0;
          end
        end
        2'd2: begin
          // Full: no push possible, a pop advances slot 1 into the head.
          if (pop) begin
            res_d[0] = res_q[1];
            tag_d[0] = tag_q[1];
            err_d[0] = err_q[1];
            count_d  = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end

    // push already excludes flush cycles, so dropped entries are never counted.
    if (push && core_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the payload slots are reset too, because the head slot drives
      // out_result/out_tag/out_err directly and those must read zero in reset.
      for (int i = 0; i < 2; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
      count_q   <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      res_q     <= res_d;
      tag_q     <= tag_d;
      err_q     <= err_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: the driver queues expected entries on accept,
// a monitor pops and compares each entry the DUT hands over.
`timescale 1ns/1ps
module tb_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t       sb [$];
  int         n_vec;
  int         n_fail;
  logic [7:0] exp_err_cnt;

  ext_pipe dut (
    .clk        (clk),
    .reset      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_off     (in_off),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one entry and wait (bounded) for it to be accepted.
  task automatic send(input logic [2:0] op, input logic [31:0] data, input logic [1:0] off,
                      input logic [4:0] tag, input logic [31:0] exp_res, input logic exp_err);
    int   waited = 0;
    bit   done   = 0;
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_off   = off;
    in_tag   = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp_res;
        e.tag = tag;
        e.err = exp_err;
        sb.push_back(e);
        if (exp_err && exp_err_cnt != 8'hFF) exp_err_cnt++;
        done = 1;
      end else if (++waited > 100) begin
        check("accept_timeout", 32'd0, 32'd1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected entry has been delivered.
  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compare each entry the consumer takes against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("tag", {27'd0, out_tag}, {27'd0, e.tag});
          check("err", {31'd0, out_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    exp_err_cnt = 8'd0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_op       = 3'd0;
    in_data     = 32'd0;
    in_off      = 2'd0;
    in_tag      = 5'd0;
    out_ready   = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Basic modes, with first-entry latency.
    send(3'd1, 32'h0000_8001, 2'd0, 5'd1, 32'hFFFF_8001, 1'b0);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    send(3'd2, 32'h0000_1234, 2'd0, 5'd2, 32'h1234_0000, 1'b0);
    send(3'd3, 32'h0000_FFFF, 2'd0, 5'd3, 32'hFFFF_FFFC, 1'b0);
    send(3'd0, 32'h0000_8001, 2'd0, 5'd4, 32'h0000_8001, 1'b0);
    send(3'd4, 32'h80FF_7F01, 2'd3, 5'd5, 32'hFFFF_FF80, 1'b0);
    send(3'd5, 32'h80FF_7F01, 2'd3, 5'd6, 32'h0000_0080, 1'b0);
    send(3'd4, 32'h80FF_7F01, 2'd1, 5'd7, 32'h0000_007F, 1'b0);
    send(3'd6, 32'h80FF_7F01, 2'd2, 5'd8, 32'hFFFF_80FF, 1'b0);
    send(3'd7, 32'h80FF_7F01, 2'd2, 5'd9, 32'h0000_80FF, 1'b0);
    send(3'd7, 32'h80FF_7F01, 2'd0, 5'd10, 32'h0000_7F01, 1'b0);
    send(3'd6, 32'h80FF_7F01, 2'd0, 5'd11, 32'h0000_7F01, 1'b0);
    // Misaligned halfword.
    send(3'd7, 32'h80FF_7F01, 2'd1, 5'd12, 32'h0000_0000, 1'b1);
    check("err_cnt_first", {24'd0, err_cnt}, 32'd1);
    wait_drain();

    // Stall: two entries fill the buffer, the third is held at the source.
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0011, 2'd0, 5'd1, 32'h0000_0011, 1'b0);
    send(3'd0, 32'h0000_0022, 2'd0, 5'd2, 32'h0000_0022, 1'b0);
    fork
      send(3'd0, 32'h0000_0033, 2'd0, 5'd3, 32'h0000_0033, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check("stall_tag", {27'd0, out_tag}, 32'd1);
          check("stall_result", out_result, 32'h0000_0011);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Flush with two entries buffered and an erroneous input in the flush cycle.
    out_ready = 1'b0;
    send(3'd0, 32'h0000_0044, 2'd0, 5'd4, 32'h0000_0044, 1'b0);
    send(3'd7, 32'h0000_0000, 2'd1, 5'd5, 32'h0000_0000, 1'b1);
    check("flush_pre_err_cnt", {24'd0, err_cnt}, 32'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = 3'd7;
    in_off   = 2'd1;
    in_tag   = 5'd6;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_err_cnt", {24'd0, err_cnt}, 32'd2);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_still_empty", {31'd0, out_valid}, 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      send(3'd7, 32'h1234_5678, 2'd1, 5'(i), 32'h0000_0000, 1'b1);
      check("sat_err_cnt", {24'd0, err_cnt}, {24'd0, exp_err_cnt});
    end
    check("sat_final", {24'd0, err_cnt}, 32'h0000_00FF);
    wait_drain();

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_8001, 2'd0, 5'd7, 32'hFFFF_8001, 1'b0);
    send(3'd2, 32'h0000_1234, 2'd0, 5'd8, 32'h1234_0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_err_cnt = 8'd0;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_result", out_result, 32'd0);
    check("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_hold_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd1, 32'h0000_8001, 2'd0, 5'd9, 32'hFFFF_8001, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
